instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  IF stage of the 5-stage pipeline. Owns the PC, issues word fetches to instruction memory
//  over a req/gnt/rvalid handshake, and presents {pc, pc_plus4, instr, valid} to the IF->ID
//  pipeline register. Honours stall from the hazard unit and PC redirects from EX.
//  At most one fetch is outstanding.
// PARAMETERS
//  RESET_PC    32'h0000_0000   PC of the first fetch after reset
//  XLEN        32              address/data width (core_pkg::XLEN)
// PORTS
//  clk              in   1     core clock
//  rst_n            in   1     synchronous, active-low reset (sampled on posedge clk)
//  stall_i          in   1     hazard unit: IF->ID register is holding this cycle
//  redirect_i       in   1     EX: taken branch/jump, or flush
//  redirect_pc_i    in   XLEN  target PC for redirect_i
//  imem_req_o       out  1     fetch request valid
//  imem_addr_o      out  XLEN  fetch address (word aligned)
//  imem_gnt_i       in   1     request accepted this cycle
//  imem_rvalid_i    in   1     response valid (>=1 cycle after gnt)
//  imem_rdata_i     in   32    fetched instruction
//  bus_out          IF2ID_if.MASTER  .data = if2id_t {pc, pc_plus4, instr, valid[, exc_misalign]}
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pc_q<=RESET_PC, state<=S_REQ, discard_q<=0, hold buf cleared;
//    imem_req_o=0 and bus_out.data='0 while rst_n=0. First request is in the cycle after release.
//  - FSM S_REQ: imem_req_o=1, imem_addr_o=pc_q. On gnt -> S_WAIT and pc_q<=pc_q+4
//    (32-bit wrap, 32'hFFFF_FFFC+4=0).
//  - S_WAIT: on rvalid and !discard_q -> if stall_i, latch {pc,instr} in hold buf -> S_HOLD;
//    else present on bus_out with valid=1 -> S_REQ (same-cycle issue of next req permitted).
//  - S_HOLD: bus_out shows hold buf, valid=1; leave to S_REQ in the first cycle with !stall_i.
//  - bus_out.data.valid=0 in every cycle without a fresh or held instruction (bubble).
//    pc_plus4=pc+4 always.
//  - Redirect (highest priority, any state): pc_q<=redirect_pc_i; hold buf dropped; output
//    valid=0 this cycle.
//    In S_WAIT without rvalid: discard_q<=1 and stay in S_WAIT; the next rvalid is dropped,
//    discard_q clears, then -> S_REQ.
//    Redirect in the same cycle as rvalid: that response is dropped, -> S_REQ.
//    Redirect in the same cycle as gnt: the granted fetch is discarded (discard_q<=1).
//  - stall_i and redirect together: redirect wins.
//  - No request is issued while in S_WAIT or S_HOLD, so outstanding <= 1.
//  - imem_addr_o holds stable while imem_req_o=1 and !imem_gnt_i.
//  - Reset mid-fetch: the in-flight response after reset is ignored (state S_REQ, rvalid
//    ignored outside S_WAIT).
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: redirect_pc_i[1:0]!=0 -> no imem request; one bubble, then
//    a single entry with valid=1, instr=NOP (32'h0000_0013), exc_misalign=1, pc=redirect_pc_i.
//    Fetch then stalls in S_REQ (req=0) until the next redirect.
//  Undefined: redirect_pc_i[1:0] forced to 2'b00; exc_misalign field absent from if2id_t.
// STRUCTURE
//  core_pkg: if2id_t, fetch_state_e {S_REQ,S_WAIT,S_HOLD}, NOP_INSTR, XLEN.
//  Sub-module pc_gen: pc_q register, +4 incrementer, redirect mux.
//  FSM, discard flag and hold buffer stay in the top.
// TESTING
//  1 Reset release, gnt=1 every cycle, rvalid 1 cycle later -> fetches 0x0,0x4,0x8,
//    each valid=1 with matching instr.
//  2 stall_i=1 for 3 cycles across rvalid of PC 0x8 -> bus_out holds 0x8, no new req;
//    resumes at 0xC.
//  3 redirect to 0x100 while in S_WAIT for 0x10 -> response for 0x10 dropped (valid=0);
//    next fetch addr 0x100.
//  4 redirect together with rvalid and stall_i=1 -> output valid=0, hold empty,
//    next req to target.
//  5 gnt withheld 4 cycles -> req=1 and addr stable; rst_n=0 mid-S_WAIT -> next addr RESET_PC.
//  6 (TRAP_EN) redirect to 0x102 -> no req, one entry exc_misalign=1, instr=0x13;
//    without macro -> fetch at 0x100.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: IF->ID payload, fetch FSM states, NOP encoding.
// FETCH_MISALIGN_TRAP_EN adds the exc_misalign flag to the IF->ID payload.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [31:0]     instr;
        logic            valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        logic            exc_misalign;
`endif
    } if2id_t;

endpackage

// File: rtl/if2id_if.sv
// IF->ID pipeline-register interface: fetch drives, decode samples.
interface IF2ID_if;
    import core_pkg::*;

    if2id_t data;

    modport MASTER (output data);
    modport SLAVE  (input  data);
endinterface

// File: rtl/instr_fetch_stage_pc_gen.sv
// PC register with +4 incrementer and redirect mux; redirect beats increment.
module pc_gen
    import core_pkg::*;
#(
    parameter int              XLEN_P   = core_pkg::XLEN,
    parameter logic [XLEN_P-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              redirect_i,
    input  logic [XLEN_P-1:0] redirect_pc_i,
    output logic [XLEN_P-1:0] pc_o
);

    logic [XLEN_P-1:0] pc_q, pc_d;

    // Next PC: redirect target, else advance past a granted fetch.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (inc_i) begin
            pc_d = pc_q + XLEN_P'(4);
        end
    end

    // PC register, synchronous reset to the boot address.
    always_ff @(posedge clk) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: single-outstanding fetch over req/gnt/rvalid, stall hold buffer,
// redirect with discard of the in-flight response.
// FETCH_MISALIGN_TRAP_EN: a misaligned redirect produces one trap entry
// (NOP, exc_misalign=1) instead of a fetch, then fetch parks until redirected.
module instr_fetch_stage
    import core_pkg::*;
#(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    IF2ID_if.MASTER         bus_out
);

    fetch_state_e    state_q, state_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] pc, tgt_pc;
    logic            req_ok, gnt_acc, fresh;
    if2id_t          if2id_d;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_pend_q, trap_pend_d;
    logic trap_stop_q, trap_stop_d;
    logic misalign_redir;
    assign tgt_pc         = redirect_pc_i;
    assign misalign_redir = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign req_ok = rst_n && (state_q == S_REQ) && !trap_pend_q && !trap_stop_q && !misalign_redir;
`else
    // Low bits are dropped so fetches are always word aligned.
    assign tgt_pc = redirect_pc_i & ~XLEN'(3);
    assign req_ok = rst_n && (state_q == S_REQ);
`endif

    assign gnt_acc     = req_ok && imem_gnt_i;
    assign fresh       = (state_q == S_WAIT) && imem_rvalid_i && !discard_q && !redirect_i;
    assign imem_req_o  = req_ok;
    assign imem_addr_o = pc;

    pc_gen #(.XLEN_P(XLEN), .RESET_PC(RESET_PC)) u_pc_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .inc_i        (gnt_acc),
        .redirect_i   (redirect_i),
        .redirect_pc_i(tgt_pc),
        .pc_o         (pc)
    );

    // Fetch FSM next state, discard/hold bookkeeping and IF->ID payload.
    always_comb begin
        state_d      = state_q;
        discard_d    = discard_q;
        fetch_pc_d   = fetch_pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        if2id_d      = '0;
        if2id_d.pc   = fetch_pc_q;

        case (state_q)
            S_REQ: begin
                if (gnt_acc) begin
                    state_d    = S_WAIT;
                    fetch_pc_d = pc;
                    discard_d  = redirect_i;   // redirected in the grant cycle: stale fetch
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    discard_d = 1'b0;
                    if (fresh && stall_i) begin
                        state_d      = S_HOLD;
                        hold_pc_d    = fetch_pc_q;
                        hold_instr_d = imem_rdata_i;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (redirect_i) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    state_d      = S_REQ;
                    hold_pc_d    = '0;
                    hold_instr_d = '0;
                end else if (!stall_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (state_q == S_HOLD && !redirect_i) begin
            if2id_d.pc    = hold_pc_q;
            if2id_d.instr = hold_instr_q;
            if2id_d.valid = 1'b1;
        end else if (fresh) begin
            if2id_d.pc    = fetch_pc_q;
            if2id_d.instr = imem_rdata_i;
            if2id_d.valid = 1'b1;
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        trap_pend_d = trap_pend_q && stall_i;
        trap_stop_d = trap_stop_q || (trap_pend_q && !stall_i);
        if (redirect_i) begin
            trap_pend_d = misalign_redir;
            trap_stop_d = 1'b0;
        end
        if (trap_pend_q && !redirect_i) begin
            if2id_d.pc           = pc;
            if2id_d.instr        = NOP_INSTR;
            if2id_d.valid        = 1'b1;
            if2id_d.exc_misalign = 1'b1;
        end
`endif

        if2id_d.pc_plus4 = if2id_d.pc + 32'd4;
        if (!rst_n) if2id_d = '0;
    end

    // State, discard flag and hold buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            discard_q    <= 1'b0;
            fetch_pc_q   <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_pend_q  <= 1'b0;
            trap_stop_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            discard_q    <= discard_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_pend_q  <= trap_pend_d;
            trap_stop_q  <= trap_stop_d;
`endif
        end
    end

    assign bus_out.data = if2id_d;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: the bench plays instruction memory and checks
// every cycle against a transaction-level model of fetch behaviour.
module tb_instr_fetch_stage;
    import core_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;

    IF2ID_if bus();

    instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .bus_out      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory side: one outstanding fetch
    bit          m_pend = 0;
    logic [31:0] m_addr = '0;
    int          m_cnt = 0;
    bit          stray_next = 0;
    int          lat_fixed = 1;   // 0 = random latency 1..3

    // reference model of the fetch stream
    logic [31:0] exp_pc = RST_PC;
    bit          kill = 0;
    bit          held = 0;
    logic [31:0] held_pc = '0;
    logic [31:0] acc_q[$];   // PCs accepted by decode
    logic [31:0] req_q[$];   // granted fetch addresses

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit st, input bit rd, input logic [31:0] tp, input bit g);
        bit stray, rv_pend, e_req, e_vld, fresh;
        logic [31:0] e_pc;
        @(posedge clk); #1;
        rst_n = r; stall_i = st; redirect_i = rd; redirect_pc_i = tp; imem_gnt_i = g;
        stray = stray_next && r;
        stray_next = 0;
        rv_pend = r && m_pend && (m_cnt == 0);
        imem_rvalid_i = rv_pend || stray;
        imem_rdata_i  = stray ? 32'hDEAD_BEEF : mem(m_addr);
        @(negedge clk);
        if (!r) begin
            chk("rst_req", 32'(imem_req_o), 0);
            chk("rst_valid", 32'(bus.data.valid), 0);
            chk("rst_pc", bus.data.pc, 0);
            chk("rst_pc4", bus.data.pc_plus4, 0);
            chk("rst_instr", bus.data.instr, 0);
            exp_pc = RST_PC; held = 0; kill = 0;
            if (m_pend) stray_next = 1;
            m_pend = 0;
            return;
        end
        e_req = !m_pend && !held;
        fresh = rv_pend && !kill && !rd;
        e_vld = !rd && (fresh || held);
        e_pc  = held ? held_pc : m_addr;
        chk("req", 32'(imem_req_o), 32'(e_req));
        if (e_req) chk("addr", imem_addr_o, exp_pc);
        chk("valid", 32'(bus.data.valid), 32'(e_vld));
        if (e_vld) begin
            chk("pc", bus.data.pc, e_pc);
            chk("instr", bus.data.instr, mem(e_pc));
            if (!st) acc_q.push_back(e_pc);
        end
        chk("pc_plus4", bus.data.pc_plus4, bus.data.pc + 32'd4);
        // advance model by one clock edge
        if (m_pend) begin
            if (rv_pend) m_pend = 0;
            else begin
                m_cnt--;
                if (rd) kill = 1;
            end
        end else if (imem_req_o && g) begin
            m_pend = 1; m_addr = imem_addr_o; kill = rd;
            m_cnt = (lat_fixed != 0) ? lat_fixed - 1 : $urandom_range(0, 2);
            req_q.push_back(imem_addr_o);
        end
        if (rd) held = 0;
        else if (fresh && st) begin held = 1; held_pc = m_addr; end
        else if (held && !st) held = 0;
        if (rd) exp_pc = tp & ~32'd3;
        else if (e_req && g) exp_pc = exp_pc + 32'd4;
    endtask

    initial begin
        int n0;
        repeat (3) step(0, 0, 0, 0, 0);
        // sequential fetch, then a 3-cycle stall across the response for 0x8
        lat_fixed = 1;
        repeat (5) step(1, 0, 0, 0, 1);
        repeat (3) step(1, 1, 0, 0, 1);
        repeat (2) step(1, 0, 0, 0, 1);
        chk("lit_acc_n", 32'(acc_q.size()), 3);
        chk("lit_acc0", acc_q[0], 32'h0);
        chk("lit_acc1", acc_q[1], 32'h4);
        chk("lit_acc2", acc_q[2], 32'h8);
        chk("lit_req3", req_q[3], 32'hC);
        step(1, 0, 0, 0, 1);                 // response for 0xC
        // redirect while waiting for 0x10
        lat_fixed = 3;
        step(1, 0, 0, 0, 1);                 // grant 0x10
        n0 = acc_q.size();
        step(1, 0, 1, 32'h100, 1);
        step(1, 0, 0, 0, 1);
        lat_fixed = 1;
        step(1, 0, 0, 0, 1);                 // dropped response
        step(1, 0, 0, 0, 1);                 // grant 0x100
        chk("lit_redir_addr", req_q[$], 32'h100);
        chk("lit_drop", 32'(acc_q.size()), 32'(n0));
        // redirect together with rvalid and stall
        step(1, 1, 1, 32'h200, 0);
        step(1, 0, 0, 0, 1);
        chk("lit_redir2_addr", req_q[$], 32'h200);
        step(1, 0, 0, 0, 0);                 // response 0x200
        // grant withheld, then reset mid-wait
        repeat (4) step(1, 0, 0, 0, 0);
        lat_fixed = 3;
        step(1, 0, 0, 0, 1);
        chk("lit_withheld", req_q[$], 32'h204);
        repeat (2) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);                 // late response arrives in S_REQ
        lat_fixed = 1;
        step(1, 0, 0, 0, 1);
        chk("lit_after_rst", req_q[$], RST_PC);
        step(1, 0, 0, 0, 0);
        // wrap from the top of the address space
        step(1, 0, 1, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("lit_wrap0", req_q[$-1], 32'hFFFF_FFFC);
        chk("lit_wrap1", req_q[$], 32'h0);
        step(1, 0, 0, 0, 0);
        // misaligned redirect target is forced onto a word boundary
        step(1, 0, 1, 32'h102, 0);
        step(1, 0, 0, 0, 1);
        chk("lit_misalign", req_q[$], 32'h100);
        // randomized traffic
        lat_fixed = 0;
        for (int i = 0; i < 1500; i++) begin
            bit r, st, rd, g;
            logic [31:0] tp;
            r  = ($urandom_range(0, 199) != 0);
            st = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 8);
            g  = ($urandom_range(0, 99) < 60);
            tp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                             : 32'($urandom_range(0, 1023));
            step(r, st, rd, tp, g);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
